// File: rtl/example_5_3_stim.sv
// Stimulus generator and response recorder for the Example 5.3 sequential machine.
// Latency: symbol k is driven after edge k*(DIV+1); its response is captured at edge k*(DIV+1)+DIV+1.
// Backpressure: none; start is a level request, and each run needs a fresh start level.
module example_5_3_stim #(
    parameter int          N_SYM = 8,
    parameter int          DIV   = 4,
    parameter logic [7:0]  SEED  = 8'hA5
) (
    input  logic               CP,
    input  logic               CR_n,
    input  logic               start,
    input  logic               y,
    input  logic               Z,
    output logic               x1,
    output logic               x2,
    output logic               step,
    output logic               busy,
    output logic               done,
    output logic [2*N_SYM-1:0] history,
    output logic [3:0]         z_count
);

    localparam int HW    = 2 * N_SYM;
    // DIV below 2 would leave no room for SETUP, so it is clamped.
    localparam int DIV_E = (DIV < 2) ? 2 : DIV;

    typedef enum logic [2:0] {IDLE, SETUP, STEP, SAMPLE, DONE} state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [7:0]  div_cnt;
    logic [3:0]  sym_cnt;
    logic [3:0]  sym_nxt;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    assign sym_nxt = sym_cnt + 4'd1;

    always_ff @(posedge CP) begin
        if (!CR_n) begin
            state   <= IDLE;
            x1      <= 1'b0;
            x2      <= 1'b0;
            step    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            history <= '0;
            z_count <= 4'd0;
            lfsr    <= SEED;
            div_cnt <= 8'd0;
            sym_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        x1      <= SEED[1];
                        x2      <= SEED[0];
                        lfsr    <= lfsr_next(SEED);
                        history <= '0;
                        z_count <= 4'd0;
                        sym_cnt <= 4'd0;
                        div_cnt <= 8'(DIV_E - 2);
                        busy    <= 1'b1;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_cnt == 8'd0) begin
                        step  <= 1'b1;
                        state <= STEP;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                STEP: begin
                    step  <= 1'b0;
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    history <= (history << 2) | HW'({y, Z});
                    z_count <= z_count + {3'b000, Z};
                    sym_cnt <= sym_nxt;
                    if (sym_nxt == 4'(N_SYM)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        x1      <= lfsr[1];
                        x2      <= lfsr[0];
                        lfsr    <= lfsr_next(lfsr);
                        div_cnt <= 8'(DIV_E - 2);
                        state   <= SETUP;
                    end
                end
                DONE: begin
                    // Leave only once start drops, so a held start never re-triggers.
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
